// File: rtl/if_id_queue.sv
// if_id_queue
//
// Instruction prefetch queue between the fetch stage and the decode stage.
// It holds up to DEPTH {next_pc, instruction} pairs so fetch keeps running
// while decode is stalled. in_ready replaces the direct freeze of the fetch
// PC register. A taken branch (flush) empties the queue in one cycle.
// All storage is registers, and out_* depend only on registered state, so
// there is no combinational path from the write side to the read side.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high in the cycle before it. Ready never depends on valid on the
// same side. The write side is in_valid/in_ready and the read side is
// out_valid/out_ready. flush overrides both sides for that cycle.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous reset, active low
//   flush           branch taken: drop queued and incoming entries
//   in_valid        fetch presents an entry
//   in_pc           fetch next_pc
//   in_instruction  fetched instruction word
//   in_ready        queue can accept (fetch freeze = in_valid & ~in_ready)
//   out_valid       head entry valid for decode
//   out_pc          head PC, 0 when empty
//   out_instruction head instruction, 0 (NOP) when empty
//   out_ready       decode consumes the head this cycle
//   count           current occupancy
module if_id_queue #(
  parameter int ADDRESS_LEN = 32,
  parameter int DEPTH       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [ADDRESS_LEN-1:0]         in_pc,
  input  logic [ADDRESS_LEN-1:0]         in_instruction,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [ADDRESS_LEN-1:0]         out_pc,
  output logic [ADDRESS_LEN-1:0]         out_instruction,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR    = PW'(1);

  logic [ADDRESS_LEN-1:0] mem_pc    [DEPTH];
  logic [ADDRESS_LEN-1:0] mem_instr [DEPTH];
  logic [PW-1:0]          wp;
  logic [PW-1:0]          rp;
  logic                   push;
  logic                   pop;

  // in_ready comes from the registered count only: a full queue refuses a
  // push even when decode pops in the same cycle, which keeps the fetch
  // freeze free of any path from decode.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Empty queue presents PC 0 and a NOP word to decode.
  assign out_pc          = out_valid ? mem_pc[rp]    : '0;
  assign out_instruction = out_valid ? mem_instr[rp] : '0;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_pc[wp]    <= in_pc;
        mem_instr[wp] <= in_instruction;
        wp            <= wp + ONE_PTR;
      end
      if (pop) begin
        rp <= rp + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int AL = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [AL-1:0] in_pc = '0;
  logic [AL-1:0] in_instruction = '0;
  logic          in_ready;
  logic          out_valid;
  logic [AL-1:0] out_pc;
  logic [AL-1:0] out_instruction;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;

  if_id_queue #(.ADDRESS_LEN(AL), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_pc(in_pc),
    .in_instruction(in_instruction),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_instruction(out_instruction),
    .out_ready(out_ready),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  logic [2*AL-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [AL-1:0] actual,
                       input logic [AL-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a transfer to decode is seen at the negedge before the edge
  // that consumes it; compare against the oldest expected entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pc 0x%0h with nothing expected", out_pc);
      end else begin
        logic [2*AL-1:0] e;
        e = exp_q.pop_front();
        check("out_pc_order", out_pc, e[2*AL-1:AL]);
        check("out_instr_order", out_instruction, e[AL-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AL-1:0] instr_of(input logic [AL-1:0] pc);
    return 32'h1300_0013 ^ (pc << 8);
  endfunction

  // Push one entry, holding it until the queue takes it (bounded).
  task automatic push_one(input logic [AL-1:0] pc, input logic [AL-1:0] ins,
                          input bit expect_out);
    bit taken;
    int guard;
    in_valid = 1'b1;
    in_pc = pc;
    in_instruction = ins;
    if (expect_out) exp_q.push_back({pc, ins});
    taken = 1'b0;
    guard = 0;
    while (!taken && guard < 50) begin
      taken = in_ready;
      step();
      guard++;
    end
    if (!taken) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: pc 0x%0h never accepted", pc);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    out_ready = 1'b1;
    while (count != 0 && guard < 50) begin
      step();
      guard++;
    end
    check("drain_count", 32'(count), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instruction, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b1;
    step();

    // Asynchronous reset mid-stream with count=3 (entries are discarded)
    push_one(32'h40, 32'hAAAA_0040, 1'b0);
    push_one(32'h44, 32'hAAAA_0044, 1'b0);
    push_one(32'h48, 32'hAAAA_0048, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_pc", out_pc, 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b1;
    step();
    // First push after release appears one cycle later
    in_valid = 1'b1;
    in_pc = 32'h4;
    in_instruction = 32'hE3A0_1005;
    exp_q.push_back({32'h4, 32'hE3A0_1005});
    step();
    in_valid = 1'b0;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_pc", out_pc, 32'h4);
    check("lat_out_instr", out_instruction, 32'hE3A0_1005);
    drain();

    // Fill / stall, then simultaneous push+pop at full
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(32'(4 * i), instr_of(32'(4 * i)), 1'b1);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_pc = 32'd20;
    in_instruction = instr_of(32'd20);
    exp_q.push_back({32'd20, instr_of(32'd20)});
    step();
    step();
    check("held_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    step();
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("push_pop_count", 32'(count), 32'd3);
    drain();

    // Streaming with wrap-around
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1;
      in_pc = 32'(4 * i);
      in_instruction = instr_of(32'(4 * i));
      exp_q.push_back({32'(4 * i), instr_of(32'(4 * i))});
      step();
      if (i == 1 || i == 7 || i == 20) check("stream_count", 32'(count), 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Flush with count=3 and an incoming entry
    out_ready = 1'b0;
    push_one(32'd8,  instr_of(32'd8),  1'b0);
    push_one(32'd12, instr_of(32'd12), 1'b0);
    push_one(32'd16, instr_of(32'd16), 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    in_valid = 1'b1;
    in_pc = 32'd20;
    in_instruction = instr_of(32'd20);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_pc", out_pc, 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_pc = 32'h100;
    in_instruction = 32'hE1A0_0000;
    exp_q.push_back({32'h100, 32'hE1A0_0000});
    step();
    in_valid = 1'b0;
    check("redirect_out_pc", out_pc, 32'h100);
    drain();

    // Flush while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'(32'h200 + 4 * i), 32'h0, 1'b0);
    check("full2_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_full_count", 32'(count), 32'd0);
    check("flush_full_in_ready", 32'(in_ready), 32'd1);

    // Pop on empty
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("empty_count", 32'(count), 32'd0);
      check("empty_out_pc", out_pc, 32'd0);
      check("empty_out_instr", out_instruction, 32'd0);
    end
    push_one(32'h300, 32'h1234_5678, 1'b1);
    drain();

    // ---------------- final report ----------------
    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction prefetch queue between the instruction-fetch stage and the decode stage. It buffers up to DEPTH fetched {next_pc, instruction} pairs so fetch can keep running while decode is stalled. Its back-pressure replaces the direct freeze of the fetch PC register, and a branch flush empties it in one cycle. All storage is register-based; there is no combinational path from the write side to the read side.

## Interface
- ADDRESS_LEN, 32: width of PC and instruction words (`ADDRESS_LEN from configs.v).
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  branch_taken from execute; discards all queued and incoming entries.
- in_valid  input  1  fetch presents a new entry this cycle.
- in_pc  input  ADDRESS_LEN  fetch next_pc (fetch PC + 4).
- in_instruction  input  ADDRESS_LEN  fetched instruction word.
- in_ready  output  1  queue can accept an entry; fetch freeze = in_valid & ~in_ready.
- out_valid  output  1  head entry is valid for decode.
- out_pc  output  ADDRESS_LEN  head entry PC, 0 when empty.
- out_instruction  output  ADDRESS_LEN  head entry instruction, 0 (NOP encoding) when empty.
- out_ready  input  1  decode consumes the head this cycle (~hazard freeze).
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- State: entry array mem[DEPTH], write pointer wp, read pointer rp (log2(DEPTH) bits, wrap modulo DEPTH), occupancy count.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH), from registered count only. There is no push-while-full, even when a pop happens in the same cycle.
- out_valid = (count != 0). out_pc/out_instruction = mem[rp] when out_valid, else 0.
- On push: mem[wp] ← {in_pc, in_instruction}; wp ← wp+1.
- On pop: rp ← rp+1.
- count ← count + push − pop. Push and pop in the same cycle leave count unchanged, and both pointers advance.
- Flush has priority over everything. It sets wp ← 0, rp ← 0, count ← 0 at the next edge. The entry presented on in_* during the flush cycle is dropped, and no pop is counted.
- Reset (rst=0, asynchronous): wp=rp=count=0 and mem cleared to 0. After reset: out_valid=0, out_pc=0, out_instruction=0, in_ready=1, count=0.
- Entries are delivered in strict FIFO order, and no entry is duplicated or lost except by flush or reset.

## Timing
- Latency: an entry pushed at edge N is visible at out_* after edge N (out_valid=1 in cycle N+1). Minimum fetch-to-decode latency is 1 cycle, with no bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0 and the fetch PC holds. in_ready returns to 1 the cycle after the first pop.
- Empty (count=0): out_valid=0 and out_* are 0. A pop request is ignored.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Flush during full or empty: the result is count=0 and in_ready=1 in the next cycle. The fetch redirect entry arrives the cycle after flush.
- rst asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.

## Test plan
- Reset: drive rst=0 mid-stream with count=3 → out_valid=0, out_pc=0, count=0, in_ready=1 immediately. After release, the first push at PC 0x4/instr 0xE3A01005 appears at out_* one cycle later.
- Fill/stall: out_ready=0, push 5 entries with PCs 4,8,12,16,20 → count reaches 4, in_ready=0 after the 4th, and the 5th is held. Set out_ready=1 → outputs 4,8,12,16,20 in order with no loss.
- Streaming with wrap: in_valid=out_ready=1 for 20 cycles with PCs 4..80 → count stays 1 and out_pc sequence is 4,8,…,80 one cycle delayed, across multiple pointer wraps.
- Flush: count=3 (PCs 8,12,16), assert flush with in_valid=1, in_pc=20 → the next cycle count=0, out_valid=0, and PC 20 is never output. Push 0x100 → out_pc=0x100.
- Simultaneous push/pop at full: count=4, in_valid=out_ready=1 → one pop, no push, count=3. The next cycle the push is accepted and count=3.
- Pop on empty: count=0, out_ready=1, in_valid=0 for 3 cycles → count stays 0, pointers unchanged, and out_* remain 0.
